// File: rtl/core_pkg.sv
// Core-wide constants shared by all pipeline and CSR blocks.
package core_pkg;

    localparam int unsigned Xlen = 32;

endpackage

// File: rtl/csr_pkg.sv
// Machine-mode CSR types: exception cause codes and trap sequencing states.
package csr_pkg;

    typedef enum logic [3:0] {
        McauseInsnMisaligned   = 4'd0,
        McauseInsnAccessFault  = 4'd1,
        McauseIllegalInsn      = 4'd2,
        McauseBreakpoint       = 4'd3,
        McauseLoadMisaligned   = 4'd4,
        McauseLoadAccessFault  = 4'd5,
        McauseStoreMisaligned  = 4'd6,
        McauseStoreAccessFault = 4'd7,
        McauseEcallU           = 4'd8,
        McauseEcallS           = 4'd9,
        McauseEcallM           = 4'd11,
        McauseInsnPageFault    = 4'd12,
        McauseLoadPageFault    = 4'd13,
        McauseStorePageFault   = 4'd15
    } csr_mcause_e;

    typedef enum logic [1:0] {
        TrapIdle     = 2'd0,
        TrapFlush    = 2'd1,
        TrapRedirect = 2'd2
    } trap_state_e;

endpackage

// File: rtl/expt_prio.sv
// Fixed-priority exception mux: fetch beats decode beats load/store.
module expt_prio
    import core_pkg::*;
    import csr_pkg::*;
(
    input  logic              if_valid_i,
    input  csr_mcause_e       if_cause_i,
    input  logic [Xlen-1:0]   if_value_i,
    input  logic              id_valid_i,
    input  csr_mcause_e       id_cause_i,
    input  logic [Xlen-1:0]   id_value_i,
    input  logic              ls_valid_i,
    input  csr_mcause_e       ls_cause_i,
    input  logic [Xlen-1:0]   ls_value_i,
    output logic              valid_o,
    output csr_mcause_e       cause_o,
    output logic [Xlen-1:0]   value_o
);

    always_comb begin
        valid_o = 1'b0;
        cause_o = McauseInsnMisaligned;
        value_o = '0;
        if (if_valid_i) begin
            valid_o = 1'b1;
            cause_o = if_cause_i;
            value_o = if_value_i;
        end else if (id_valid_i) begin
            valid_o = 1'b1;
            cause_o = id_cause_i;
            value_o = id_value_i;
        end else if (ls_valid_i) begin
            valid_o = 1'b1;
            cause_o = ls_cause_i;
            value_o = ls_value_i;
        end
    end

endmodule

// File: rtl/trap_ctrl.sv
// Trap sequencer: reports the committing exception to the CSR unit, then
// flushes the pipeline and hands the trap/mret target to fetch.
module trap_ctrl
    import core_pkg::*;
    import csr_pkg::*;
#(
    parameter int unsigned FlushCycles = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              commit_valid_i,
    input  logic              if_expt_valid_i,
    input  csr_mcause_e       if_expt_cause_i,
    input  logic [Xlen-1:0]   if_expt_value_i,
    input  logic              id_expt_valid_i,
    input  csr_mcause_e       id_expt_cause_i,
    input  logic [Xlen-1:0]   id_expt_value_i,
    input  logic              ls_expt_valid_i,
    input  csr_mcause_e       ls_expt_cause_i,
    input  logic [Xlen-1:0]   ls_expt_value_i,
    output logic              expt_valid_o,
    output csr_mcause_e       expt_cause_o,
    output logic [Xlen-1:0]   expt_value_o,
    input  logic              raise_trap_i,
    input  logic [Xlen-1:0]   trap_vector_i,
    output logic              flush_o,
    output logic              redirect_valid_o,
    output logic [Xlen-1:0]   redirect_pc_o,
    input  logic              redirect_ready_i,
    output logic              stall_o
);

    localparam logic [3:0]      FlushCntInit = 4'(FlushCycles - 1);
    localparam logic [Xlen-1:0] PcAlignMask  = ~Xlen'(1);

    trap_state_e     state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [Xlen-1:0] target_q, target_d;

    logic            sel_valid;
    csr_mcause_e     sel_cause;
    logic [Xlen-1:0] sel_value;

    expt_prio u_expt_prio (
        .if_valid_i (if_expt_valid_i),
        .if_cause_i (if_expt_cause_i),
        .if_value_i (if_expt_value_i),
        .id_valid_i (id_expt_valid_i),
        .id_cause_i (id_expt_cause_i),
        .id_value_i (id_expt_value_i),
        .ls_valid_i (ls_expt_valid_i),
        .ls_cause_i (ls_expt_cause_i),
        .ls_value_i (ls_expt_value_i),
        .valid_o    (sel_valid),
        .cause_o    (sel_cause),
        .value_o    (sel_value)
    );

    // Sources are masked while a trap is in flight; the CSR unit must only
    // see exceptions from a committing instruction.
    always_comb begin
        expt_valid_o = commit_valid_i && sel_valid && (state_q == TrapIdle);
        expt_cause_o = McauseInsnMisaligned;
        expt_value_o = '0;
        if (expt_valid_o) begin
            expt_cause_o = sel_cause;
            expt_value_o = sel_value;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        target_d = target_q;
        unique case (state_q)
            TrapIdle: begin
                if (raise_trap_i) begin
                    state_d  = TrapFlush;
                    cnt_d    = FlushCntInit;
                    target_d = trap_vector_i & PcAlignMask;
                end
            end
            TrapFlush: begin
                if (cnt_q == 4'd0) begin
                    state_d = TrapRedirect;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            TrapRedirect: begin
                // Acceptance wins over any raise in the same cycle.
                if (redirect_ready_i) begin
                    state_d = TrapIdle;
                end
            end
            default: state_d = TrapIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= TrapIdle;
            cnt_q    <= 4'd0;
            target_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            target_q <= target_d;
        end
    end

    assign flush_o          = (state_q == TrapFlush);
    assign redirect_valid_o = (state_q == TrapRedirect);
    assign redirect_pc_o    = target_q;
    assign stall_o          = (state_q != TrapIdle);

endmodule

// File: tb/tb_trap_ctrl.sv
// Self-checking bench for trap_ctrl: priority table, directed trap sequences,
// then randomized traffic against a cycle-age reference model.
module tb_trap_ctrl;
    import core_pkg::*;
    import csr_pkg::*;

    localparam int unsigned FC = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            commit_valid;
    logic            if_v, id_v, ls_v;
    csr_mcause_e     if_c, id_c, ls_c;
    logic [Xlen-1:0] if_val, id_val, ls_val;
    logic            expt_valid;
    csr_mcause_e     expt_cause;
    logic [Xlen-1:0] expt_value;
    logic            raise_trap;
    logic [Xlen-1:0] trap_vector;
    logic            flush;
    logic            redirect_valid;
    logic [Xlen-1:0] redirect_pc;
    logic            redirect_ready;
    logic            stall;

    always #5 clk = ~clk;

    trap_ctrl #(.FlushCycles(FC)) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .commit_valid_i   (commit_valid),
        .if_expt_valid_i  (if_v),
        .if_expt_cause_i  (if_c),
        .if_expt_value_i  (if_val),
        .id_expt_valid_i  (id_v),
        .id_expt_cause_i  (id_c),
        .id_expt_value_i  (id_val),
        .ls_expt_valid_i  (ls_v),
        .ls_expt_cause_i  (ls_c),
        .ls_expt_value_i  (ls_val),
        .expt_valid_o     (expt_valid),
        .expt_cause_o     (expt_cause),
        .expt_value_o     (expt_value),
        .raise_trap_i     (raise_trap),
        .trap_vector_i    (trap_vector),
        .flush_o          (flush),
        .redirect_valid_o (redirect_valid),
        .redirect_pc_o    (redirect_pc),
        .redirect_ready_i (redirect_ready),
        .stall_o          (stall)
    );

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Registered outputs are sampled 2 time units after the rising edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_inputs();
        commit_valid   = 1'b0;
        if_v = 1'b0; id_v = 1'b0; ls_v = 1'b0;
        if_c = McauseInsnAccessFault; if_val = 32'h0000_1000;
        id_c = McauseIllegalInsn;     id_val = 32'h0000_3000;
        ls_c = McauseLoadAccessFault; ls_val = 32'h0000_2004;
        raise_trap     = 1'b0;
        trap_vector    = '0;
        redirect_ready = 1'b0;
    endtask

    // Raise a trap from IDLE and return in cycle T+1.
    task automatic start_trap(input logic [Xlen-1:0] vec);
        trap_vector = vec;
        raise_trap  = 1'b1;
        tick();
        raise_trap  = 1'b0;
    endtask

    typedef struct {
        logic            commit;
        logic            ifv;
        logic            idv;
        logic            lsv;
        logic            exp_valid;
        logic [3:0]      exp_cause;
        logic [Xlen-1:0] exp_value;
    } prio_vec_t;

    prio_vec_t ptab[8];

    // Reference model state: trap age counts cycles since raise was taken.
    bit              m_busy;
    int unsigned     m_age;
    logic [Xlen-1:0] m_tgt;

    csr_mcause_e causes[8];

    initial begin
        logic [Xlen-1:0] held_pc;

        ptab[0] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'd1, 32'h0000_1000};
        ptab[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'd5, 32'h0000_2004};
        ptab[2] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 4'd2, 32'h0000_3000};
        ptab[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'd1, 32'h0000_1000};
        ptab[4] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'd2, 32'h0000_3000};
        ptab[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0000_0000};
        ptab[6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 32'h0000_0000};
        ptab[7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'd1, 32'h0000_1000};

        causes = '{McauseInsnMisaligned, McauseInsnAccessFault, McauseIllegalInsn,
                   McauseBreakpoint, McauseLoadAccessFault, McauseStoreAccessFault,
                   McauseEcallM, McauseLoadPageFault};

        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("reset_flush", 64'(flush), 64'd0);
        check("reset_redirect_valid", 64'(redirect_valid), 64'd0);
        check("reset_stall", 64'(stall), 64'd0);
        check("reset_redirect_pc", 64'(redirect_pc), 64'd0);
        check("reset_expt_valid", 64'(expt_valid), 64'd0);

        // Priority table in IDLE
        foreach (ptab[i]) begin
            commit_valid = ptab[i].commit;
            if_v = ptab[i].ifv;
            id_v = ptab[i].idv;
            ls_v = ptab[i].lsv;
            settle();
            check($sformatf("prio%0d_valid", i), 64'(expt_valid), 64'(ptab[i].exp_valid));
            check($sformatf("prio%0d_cause", i), 64'(expt_cause), 64'(ptab[i].exp_cause));
            check($sformatf("prio%0d_value", i), 64'(expt_value), 64'(ptab[i].exp_value));
        end
        clear_inputs();
        tick();

        // Basic trap sequence with odd vector
        start_trap(32'h0000_0101);
        check("seq_t1_flush", 64'(flush), 64'd1);
        check("seq_t1_stall", 64'(stall), 64'd1);
        check("seq_t1_rv", 64'(redirect_valid), 64'd0);
        tick();
        check("seq_t2_flush", 64'(flush), 64'd1);
        check("seq_t2_rv", 64'(redirect_valid), 64'd0);
        tick();
        check("seq_t3_flush", 64'(flush), 64'd0);
        check("seq_t3_rv", 64'(redirect_valid), 64'd1);
        check("seq_t3_pc", 64'(redirect_pc), 64'h100);
        redirect_ready = 1'b1;
        tick();
        redirect_ready = 1'b0;
        check("seq_t4_stall", 64'(stall), 64'd0);
        check("seq_t4_rv", 64'(redirect_valid), 64'd0);

        // Backpressure: ready low for 5 cycles in REDIRECT
        start_trap(32'h4000_1234);
        tick();
        tick();
        held_pc = 32'h4000_1234;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp%0d_rv", i), 64'(redirect_valid), 64'd1);
            check($sformatf("bp%0d_pc", i), 64'(redirect_pc), 64'(held_pc));
            tick();
        end
        check("bp_final_rv", 64'(redirect_valid), 64'd1);
        redirect_ready = 1'b1;
        tick();
        check("bp_accept_rv", 64'(redirect_valid), 64'd0);
        check("bp_accept_stall", 64'(stall), 64'd0);
        tick();
        check("bp_once_stall", 64'(stall), 64'd0);
        check("bp_once_flush", 64'(flush), 64'd0);
        redirect_ready = 1'b0;

        // Busy masking during FLUSH
        start_trap(32'h0000_0300);
        trap_vector  = 32'h0000_0200;
        raise_trap   = 1'b1;
        commit_valid = 1'b1;
        id_v         = 1'b1;
        settle();
        check("mask_expt_valid", 64'(expt_valid), 64'd0);
        check("mask_expt_cause", 64'(expt_cause), 64'd0);
        tick();
        clear_inputs();
        check("mask_t2_flush", 64'(flush), 64'd1);
        tick();
        check("mask_t3_rv", 64'(redirect_valid), 64'd1);
        check("mask_t3_pc", 64'(redirect_pc), 64'h300);
        redirect_ready = 1'b1;
        tick();
        redirect_ready = 1'b0;
        check("mask_idle_stall", 64'(stall), 64'd0);

        // Raise coincident with acceptance is dropped
        start_trap(32'h0000_0500);
        tick();
        tick();
        redirect_ready = 1'b1;
        raise_trap     = 1'b1;
        trap_vector    = 32'h0000_0600;
        tick();
        redirect_ready = 1'b0;
        raise_trap     = 1'b0;
        check("coinc_stall", 64'(stall), 64'd0);
        tick();
        check("coinc_flush", 64'(flush), 64'd0);
        check("coinc_stall2", 64'(stall), 64'd0);

        // mret return with no exception sources
        commit_valid = 1'b1;
        trap_vector  = 32'h8000_0040;
        raise_trap   = 1'b1;
        settle();
        check("mret_t0_ev", 64'(expt_valid), 64'd0);
        tick();
        raise_trap = 1'b0;
        check("mret_t1_flush", 64'(flush), 64'd1);
        check("mret_t1_ev", 64'(expt_valid), 64'd0);
        tick();
        check("mret_t2_flush", 64'(flush), 64'd1);
        tick();
        check("mret_t3_rv", 64'(redirect_valid), 64'd1);
        check("mret_t3_pc", 64'(redirect_pc), 64'h8000_0040);
        check("mret_t3_ev", 64'(expt_valid), 64'd0);
        redirect_ready = 1'b1;
        tick();
        clear_inputs();
        check("mret_idle_stall", 64'(stall), 64'd0);

        // Reset mid-REDIRECT
        start_trap(32'h0000_0080);
        tick();
        tick();
        check("rstmid_rv", 64'(redirect_valid), 64'd1);
        check("rstmid_pc", 64'(redirect_pc), 64'h80);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rstmid_after_rv", 64'(redirect_valid), 64'd0);
        check("rstmid_after_stall", 64'(stall), 64'd0);
        check("rstmid_after_flush", 64'(flush), 64'd0);
        check("rstmid_after_pc", 64'(redirect_pc), 64'd0);
        commit_valid = 1'b1;
        if_v = 1'b1;
        settle();
        check("rstmid_idle_ev", 64'(expt_valid), 64'd1);
        clear_inputs();

        // Randomized traffic against the reference model
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_busy = 1'b0;
        m_age  = 0;
        m_tgt  = '0;
        for (int n = 0; n < 600; n++) begin
            logic            e_valid;
            logic [3:0]      e_cause;
            logic [Xlen-1:0] e_value;
            logic            e_flush, e_rv;

            rst            = ($urandom_range(0, 63) == 0);
            commit_valid   = $urandom_range(0, 1) == 1;
            if_v           = ($urandom_range(0, 3) == 0);
            id_v           = ($urandom_range(0, 3) == 0);
            ls_v           = ($urandom_range(0, 3) == 0);
            if_c           = causes[$urandom_range(0, 7)];
            id_c           = causes[$urandom_range(0, 7)];
            ls_c           = causes[$urandom_range(0, 7)];
            if_val         = $urandom;
            id_val         = $urandom;
            ls_val         = $urandom;
            raise_trap     = ($urandom_range(0, 4) == 0);
            trap_vector    = $urandom;
            redirect_ready = $urandom_range(0, 1) == 1;
            settle();

            e_valid = 1'b0;
            e_cause = 4'd0;
            e_value = '0;
            if (commit_valid && !m_busy) begin
                if (if_v)      begin e_valid = 1'b1; e_cause = if_c; e_value = if_val; end
                else if (id_v) begin e_valid = 1'b1; e_cause = id_c; e_value = id_val; end
                else if (ls_v) begin e_valid = 1'b1; e_cause = ls_c; e_value = ls_val; end
            end
            e_flush = m_busy && (m_age >= 1) && (m_age <= FC);
            e_rv    = m_busy && (m_age > FC);

            check("rnd_expt_valid", 64'(expt_valid), 64'(e_valid));
            check("rnd_expt_cause", 64'(expt_cause), 64'(e_cause));
            check("rnd_expt_value", 64'(expt_value), 64'(e_value));
            check("rnd_flush", 64'(flush), 64'(e_flush));
            check("rnd_redirect_valid", 64'(redirect_valid), 64'(e_rv));
            check("rnd_stall", 64'(stall), 64'(m_busy));
            if (e_rv) check("rnd_redirect_pc", 64'(redirect_pc), 64'(m_tgt));

            if (rst) begin
                m_busy = 1'b0;
                m_tgt  = '0;
            end else if (m_busy) begin
                if (m_age > FC && redirect_ready) m_busy = 1'b0;
                else m_age++;
            end else if (raise_trap) begin
                m_busy = 1'b1;
                m_age  = 1;
                m_tgt  = {trap_vector[Xlen-1:1], 1'b0};
            end
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
